// File: rtl/cpu_pkg.sv
// Shared definitions for the arithmetic sequencer: word size, opcode encodings
// and the control FSM state type.
package cpu_pkg;

  localparam int WORD_SIZE = 19;
  localparam int CNT_W     = 5;

  typedef enum logic [4:0] {
    OP_ADD = 5'd0,
    OP_SUB = 5'd1,
    OP_MUL = 5'd2,
    OP_DIV = 5'd3,
    OP_INC = 5'd4,
    OP_DEC = 5'd5
  } opcode_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/arith_iter_core.sv
// Iterative datapath shared by MUL (LSB-first shift-add) and DIV (MSB-first
// restoring division); one iteration per asserted step.
module arith_iter_core #(
  parameter int WORD_SIZE = cpu_pkg::WORD_SIZE
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic                 step,
  input  logic                 is_div,
  input  logic [WORD_SIZE-1:0] operand_a,
  input  logic [WORD_SIZE-1:0] operand_b,
  output logic [WORD_SIZE-1:0] result,
  output logic [WORD_SIZE-1:0] remainder,
  output logic                 high_nonzero
);

  localparam int W = WORD_SIZE;

  // Upper half: MUL partial product / DIV partial remainder.
  // Lower half: MUL multiplier bits / DIV dividend bits shifting into quotient.
  logic [2*W-1:0] acc_reg, acc_next;
  logic [W-1:0]   b_reg;
  logic           div_reg;

  logic [W:0]     add_sum;
  logic [W:0]     rem_shift;
  logic [W-1:0]   rem_diff;
  logic           rem_ge;

  always_comb begin
    add_sum   = {1'b0, acc_reg[2*W-1:W]} + {1'b0, b_reg};
    rem_shift = acc_reg[2*W-1:W-1];
    rem_ge    = rem_shift >= {1'b0, b_reg};
    // When rem_ge holds the true difference is below the divisor, so W bits suffice.
    rem_diff  = rem_shift[W-1:0] - b_reg;
    acc_next  = acc_reg;
    if (div_reg) begin
      if (rem_ge) begin
        acc_next = {rem_diff, acc_reg[W-2:0], 1'b1};
      end else begin
        acc_next = {rem_shift[W-1:0], acc_reg[W-2:0], 1'b0};
      end
    end else begin
      if (acc_reg[0]) begin
        acc_next = {add_sum, acc_reg[W-1:1]};
      end else begin
        acc_next = {1'b0, acc_reg[2*W-1:1]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_reg <= '0;
      b_reg   <= '0;
      div_reg <= 1'b0;
    end else if (load) begin
      acc_reg <= {{W{1'b0}}, operand_a};
      b_reg   <= operand_b;
      div_reg <= is_div;
    end else if (step) begin
      acc_reg <= acc_next;
    end
  end

  assign result       = acc_reg[W-1:0];
  assign remainder    = acc_reg[2*W-1:W];
  assign high_nonzero = |acc_reg[2*W-1:W];

endmodule

// File: rtl/arith_sequencer.sv
// Valid/ready arithmetic sequencer: single-cycle ADD/SUB/INC/DEC, iterative
// MUL/DIV through arith_iter_core, results held until the consumer accepts.
module arith_sequencer #(
  parameter int WORD_SIZE = cpu_pkg::WORD_SIZE
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_valid,
  output logic                 start_ready,
  input  logic [4:0]           opcode,
  input  logic [WORD_SIZE-1:0] operand_1,
  input  logic [WORD_SIZE-1:0] operand_2,
  output logic                 result_valid,
  input  logic                 result_ready,
  output logic [WORD_SIZE-1:0] result,
  output logic [WORD_SIZE-1:0] remainder,
  output logic                 carry,
  output logic                 div_by_zero,
  output logic                 illegal_op
);

  import cpu_pkg::*;

  localparam int W = WORD_SIZE;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   count_reg;
  logic [W-1:0]       result_reg, remainder_reg;
  logic               carry_reg, dbz_reg, illegal_reg;
  logic               iter_sel_reg, mul_sel_reg;

  logic               accept;
  logic               core_load, core_step;
  logic [W-1:0]       core_result, core_remainder;
  logic               core_high_nonzero;

  logic [W-1:0]       q_result, q_remainder;
  logic               q_carry, q_dbz, q_illegal, q_iter, q_mul;

  assign accept = start_valid && (state_reg == IDLE);

  // Outcome of the presented operation, evaluated for the accepting edge.
  always_comb begin
    q_result    = '0;
    q_remainder = '0;
    q_carry     = 1'b0;
    q_dbz       = 1'b0;
    q_illegal   = 1'b0;
    q_iter      = 1'b0;
    q_mul       = 1'b0;
    case (opcode)
      OP_ADD: {q_carry, q_result} = {1'b0, operand_1} + {1'b0, operand_2};
      OP_SUB: {q_carry, q_result} = {1'b0, operand_1} - {1'b0, operand_2};
      OP_INC: {q_carry, q_result} = {1'b0, operand_1} + (W+1)'(1);
      OP_DEC: {q_carry, q_result} = {1'b0, operand_1} - (W+1)'(1);
      OP_MUL: begin
        q_iter = 1'b1;
        q_mul  = 1'b1;
      end
      OP_DIV: begin
        if (operand_2 == '0) begin
          q_result    = '1;
          q_remainder = operand_1;
          q_dbz       = 1'b1;
        end else begin
          q_iter = 1'b1;
        end
      end
      default: q_illegal = 1'b1;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    core_load  = 1'b0;
    core_step  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start_valid) begin
          state_next = q_iter ? RUN : DONE;
          core_load  = q_iter;
        end
      end
      RUN: begin
        core_step = 1'b1;
        if (count_reg == CNT_W'(1)) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (result_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      count_reg     <= '0;
      result_reg    <= '0;
      remainder_reg <= '0;
      carry_reg     <= 1'b0;
      dbz_reg       <= 1'b0;
      illegal_reg   <= 1'b0;
      iter_sel_reg  <= 1'b0;
      mul_sel_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (core_load) begin
        count_reg <= CNT_W'(W);
      end else if (core_step) begin
        count_reg <= count_reg - CNT_W'(1);
      end
      if (accept) begin
        result_reg    <= q_result;
        remainder_reg <= q_remainder;
        carry_reg     <= q_carry;
        dbz_reg       <= q_dbz;
        illegal_reg   <= q_illegal;
        iter_sel_reg  <= q_iter;
        mul_sel_reg   <= q_mul;
      end
    end
  end

  arith_iter_core #(
    .WORD_SIZE (W)
  ) u_iter_core (
    .clk          (clk),
    .rst_n        (rst_n),
    .load         (core_load),
    .step         (core_step),
    .is_div       (opcode == OP_DIV),
    .operand_a    (operand_1),
    .operand_b    (operand_2),
    .result       (core_result),
    .remainder    (core_remainder),
    .high_nonzero (core_high_nonzero)
  );

  // The core stops stepping in DONE, so its accumulator is as stable as the registers.
  assign result       = iter_sel_reg ? core_result : result_reg;
  assign remainder    = iter_sel_reg ? (mul_sel_reg ? '0 : core_remainder) : remainder_reg;
  assign carry        = iter_sel_reg ? (mul_sel_reg && core_high_nonzero) : carry_reg;
  assign div_by_zero  = dbz_reg;
  assign illegal_op   = illegal_reg;
  assign start_ready  = (state_reg == IDLE);
  assign result_valid = (state_reg == DONE);

endmodule

// File: tb/tb_arith_sequencer.sv
// Directed-vector bench for arith_sequencer: table of ops with hand-computed
// results, plus DONE-hold and mid-RUN reset sequences.
module tb_arith_sequencer;

  localparam int W = 19;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start_valid;
  logic         start_ready;
  logic [4:0]   opcode;
  logic [W-1:0] operand_1, operand_2;
  logic         result_valid;
  logic         result_ready;
  logic [W-1:0] result, remainder;
  logic         carry, div_by_zero, illegal_op;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    string        name;
    logic [4:0]   op;
    logic [W-1:0] a, b;
    logic [W-1:0] res, rem;
    logic         c, dz, il;
    int           lat;
  } vec_t;

  vec_t vecs[17];

  arith_sequencer #(.WORD_SIZE(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_valid  (start_valid),
    .start_ready  (start_ready),
    .opcode       (opcode),
    .operand_1    (operand_1),
    .operand_2    (operand_2),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .result       (result),
    .remainder    (remainder),
    .carry        (carry),
    .div_by_zero  (div_by_zero),
    .illegal_op   (illegal_op)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int k;
    @(negedge clk);
    opcode      = v.op;
    operand_1   = v.a;
    operand_2   = v.b;
    start_valid = 1'b1;
    check({v.name, " start_ready before"}, 32'(start_ready), 32'd1);
    @(posedge clk);
    #1;
    // Disturb inputs after acceptance; the registered operation must be unaffected.
    start_valid = 1'b0;
    opcode      = v.op ^ 5'd1;
    operand_1   = W'($urandom);
    operand_2   = W'($urandom);
    k = 0;
    while (!result_valid && k < 60) begin
      @(posedge clk);
      #1;
      k++;
    end
    check({v.name, " latency"},   32'(k),           32'(v.lat));
    check({v.name, " result"},    32'(result),      32'(v.res));
    check({v.name, " remainder"}, 32'(remainder),   32'(v.rem));
    check({v.name, " carry"},     32'(carry),       32'(v.c));
    check({v.name, " div0"},      32'(div_by_zero), 32'(v.dz));
    check({v.name, " illegal"},   32'(illegal_op),  32'(v.il));
    check({v.name, " ready_busy"}, 32'(start_ready), 32'd0);
    $display("%s op=%0d a=%h b=%h -> result=%h rem=%h c=%b dz=%b il=%b lat=%0d",
             v.name, v.op, v.a, v.b, result, remainder, carry, div_by_zero, illegal_op, k);
    @(negedge clk);
    result_ready = 1'b1;
    @(posedge clk);
    #1;
    result_ready = 1'b0;
    check({v.name, " valid_drop"}, 32'(result_valid), 32'd0);
    check({v.name, " ready_back"}, 32'(start_ready),  32'd1);
  endtask

  initial begin
    int k;
    vec_t v;
    vecs[0]  = '{"add_wrap",  5'd0, 19'h7FFFF, 19'h00001, 19'h00000, 19'h0, 1'b1, 1'b0, 1'b0, 0};
    vecs[1]  = '{"add_small", 5'd0, 19'd2,     19'd3,     19'd5,     19'h0, 1'b0, 1'b0, 1'b0, 0};
    vecs[2]  = '{"sub_borrow",5'd1, 19'd5,     19'd7,     19'h7FFFE, 19'h0, 1'b1, 1'b0, 1'b0, 0};
    vecs[3]  = '{"sub_plain", 5'd1, 19'd7,     19'd5,     19'd2,     19'h0, 1'b0, 1'b0, 1'b0, 0};
    vecs[4]  = '{"mul_300x500",5'd2,19'd300,   19'd500,   19'h249F0, 19'h0, 1'b0, 1'b0, 1'b0, 19};
    vecs[5]  = '{"mul_1kx1k", 5'd2, 19'd1024,  19'd1024,  19'h00000, 19'h0, 1'b1, 1'b0, 1'b0, 19};
    vecs[6]  = '{"mul_maxx2", 5'd2, 19'h7FFFF, 19'd2,     19'h7FFFE, 19'h0, 1'b1, 1'b0, 1'b0, 19};
    vecs[7]  = '{"div_100_7", 5'd3, 19'd100,   19'd7,     19'd14,    19'd2, 1'b0, 1'b0, 1'b0, 19};
    vecs[8]  = '{"div_by0",   5'd3, 19'd5,     19'd0,     19'h7FFFF, 19'd5, 1'b0, 1'b1, 1'b0, 0};
    vecs[9]  = '{"div_maxmax",5'd3, 19'h7FFFF, 19'h7FFFF, 19'd1,     19'd0, 1'b0, 1'b0, 1'b0, 19};
    vecs[10] = '{"div_3_10",  5'd3, 19'd3,     19'd10,    19'd0,     19'd3, 1'b0, 1'b0, 1'b0, 19};
    vecs[11] = '{"inc_wrap",  5'd4, 19'h7FFFF, 19'd9,     19'd0,     19'h0, 1'b1, 1'b0, 1'b0, 0};
    vecs[12] = '{"inc_plain", 5'd4, 19'd41,    19'd100,   19'd42,    19'h0, 1'b0, 1'b0, 1'b0, 0};
    vecs[13] = '{"dec_wrap",  5'd5, 19'd0,     19'd3,     19'h7FFFF, 19'h0, 1'b1, 1'b0, 1'b0, 0};
    vecs[14] = '{"dec_plain", 5'd5, 19'd10,    19'd0,     19'd9,     19'h0, 1'b0, 1'b0, 1'b0, 0};
    vecs[15] = '{"illegal_9", 5'd9, 19'd123,   19'd456,   19'd0,     19'h0, 1'b0, 1'b0, 1'b1, 0};
    vecs[16] = '{"illegal_31",5'd31,19'h7FFFF, 19'h7FFFF, 19'd0,     19'h0, 1'b0, 1'b0, 1'b1, 0};

    rst_n = 1'b0; start_valid = 1'b0; result_ready = 1'b0;
    opcode = '0; operand_1 = '0; operand_2 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst result",      32'(result),       32'd0);
    check("rst remainder",   32'(remainder),    32'd0);
    check("rst flags",       32'({carry, div_by_zero, illegal_op}), 32'd0);
    check("rst valid",       32'(result_valid), 32'd0);
    check("rst start_ready", 32'(start_ready),  32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 17; i++) begin
      run_vec(vecs[i]);
    end

    // Hold DONE with result_ready low while inputs churn.
    @(negedge clk);
    opcode = 5'd2; operand_1 = 19'd300; operand_2 = 19'd500; start_valid = 1'b1;
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    k = 0;
    while (!result_valid && k < 60) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("hold latency", 32'(k), 32'd19);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      start_valid = ~start_valid;
      opcode      = 5'(c);
      operand_1   = W'($urandom);
      operand_2   = W'($urandom);
      @(posedge clk);
      #1;
      check("hold result",      32'(result),       32'h249F0);
      check("hold remainder",   32'(remainder),    32'd0);
      check("hold carry",       32'(carry),        32'd0);
      check("hold valid",       32'(result_valid), 32'd1);
      check("hold start_ready", 32'(start_ready),  32'd0);
    end
    $display("hold: 5 cycles in DONE, result=%h start_ready=%b", result, start_ready);
    @(negedge clk);
    start_valid = 1'b0;
    result_ready = 1'b1;
    @(posedge clk);
    #1;
    result_ready = 1'b0;
    check("hold release ready", 32'(start_ready),  32'd1);
    check("hold release valid", 32'(result_valid), 32'd0);

    // Reset asserted during the 10th RUN cycle of a MUL.
    @(negedge clk);
    opcode = 5'd2; operand_1 = 19'd1024; operand_2 = 19'd1024; start_valid = 1'b1;
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("midrun busy", 32'(start_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("midrun rst result",    32'(result),       32'd0);
    check("midrun rst remainder", 32'(remainder),    32'd0);
    check("midrun rst flags",     32'({carry, div_by_zero, illegal_op}), 32'd0);
    check("midrun rst valid",     32'(result_valid), 32'd0);
    check("midrun rst ready",     32'(start_ready),  32'd1);
    $display("midrun reset: result=%h valid=%b start_ready=%b", result, result_valid, start_ready);
    @(negedge clk);
    rst_n = 1'b1;
    v = '{"post_rst_add", 5'd0, 19'd2, 19'd3, 19'd5, 19'h0, 1'b0, 1'b0, 1'b0, 0};
    run_vec(v);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/arith_sequencer.md
ARITH_SEQUENCER -- requirements
Module: arith_sequencer

Interface
REQ-001 Parameter: WORD_SIZE, default 19, width of operands and results.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 start_valid  input  1  requester presents an operation.
REQ-005 start_ready  output  1  sequencer can accept an operation.
REQ-006 opcode  input  5  operation code, encodings from shared package.
REQ-007 operand_1  input  WORD_SIZE  first operand; dividend for DIV.
REQ-008 operand_2  input  WORD_SIZE  second operand; divisor for DIV; ignored for INC/DEC.
REQ-009 result_valid  output  1  result and flags are valid.
REQ-010 result_ready  input  1  consumer accepts the result.
REQ-011 result  output  WORD_SIZE  sum, difference, low product or quotient.
REQ-012 remainder  output  WORD_SIZE  DIV remainder; 0 for all other ops.
REQ-013 carry  output  1  ADD/INC carry-out; SUB/DEC borrow; MUL product exceeds WORD_SIZE bits.
REQ-014 div_by_zero  output  1  DIV with operand_2 == 0.
REQ-015 illegal_op  output  1  opcode not among the six defined.

Function
REQ-016 Opcodes SHALL be ADD=0, SUB=1, MUL=2, DIV=3, INC=4, DEC=5; all others illegal.
REQ-017 FSM states SHALL be IDLE, RUN, DONE; start_ready = 1 only in IDLE.
REQ-018 Acceptance SHALL occur on an edge where start_valid && start_ready; opcode and operands are registered at that edge and later input changes have no effect.
REQ-019 ADD, SUB, INC, DEC, illegal opcode and DIV-by-zero SHALL go IDLE->DONE at the accepting edge, so result_valid is high in the following cycle.
REQ-020 MUL and DIV (nonzero divisor) SHALL go IDLE->RUN, load a 5-bit iteration counter with WORD_SIZE, perform one iteration per cycle, and enter DONE at the edge completing iteration WORD_SIZE (result_valid high after the 19th edge following acceptance).
REQ-021 MUL SHALL be radix-2 shift-add over a 2*WORD_SIZE accumulator; result = low WORD_SIZE bits; carry = |high bits.
REQ-022 DIV SHALL be unsigned restoring division, MSB first; result = quotient, remainder = remainder.
REQ-023 All arithmetic SHALL be unsigned modulo 2^WORD_SIZE; INC adds 1, DEC subtracts 1.
REQ-024 DIV-by-zero SHALL give result = all ones, remainder = operand_1, div_by_zero = 1, carry = 0.
REQ-025 Illegal opcode SHALL give result = 0, remainder = 0, illegal_op = 1, all other flags 0.
REQ-026 In DONE, result, remainder and all flags SHALL stay stable until result_valid && result_ready; on that edge the FSM returns to IDLE and result_valid drops.
REQ-027 start_valid asserted while not in IDLE SHALL be ignored; there is no overlap of transactions, and start_ready rises the cycle after the result handshake.
REQ-028 Flags not applicable to an op SHALL be 0.

Reset
REQ-029 At an edge with rst_n = 0: state = IDLE, counter = 0, result = remainder = 0, all flags = 0, result_valid = 0; start_ready = 1 in the following cycle.
REQ-030 Reset SHALL take priority over every transition, including mid-RUN and in DONE; any in-flight operation is discarded with no result produced.

Structure
REQ-031 WORD_SIZE, the opcode enum type and the FSM state enum SHALL live in shared package cpu_pkg.
REQ-032 The iterative MUL/DIV datapath (accumulator, shift, conditional add/subtract) SHALL be one sub-module, arith_iter_core, controlled by the FSM in arith_sequencer.

Verification
REQ-033 ADD 0x7FFFF + 0x00001 -> result 0x00000, carry 1, result_valid the cycle after acceptance.
REQ-034 MUL 300 * 500 -> result 150000 (0x249F0), carry 0, result_valid after the 19th edge following acceptance; MUL 1024 * 1024 -> result 0, carry 1.
REQ-035 DIV 100 / 7 -> result 14, remainder 2; DIV 5 / 0 -> result 0x7FFFF, remainder 5, div_by_zero 1, single-cycle latency.
REQ-036 DEC 0 -> result 0x7FFFF, carry 1; opcode 9 -> illegal_op 1, result 0.
REQ-037 Hold result_ready = 0 for 5 cycles in DONE while toggling start_valid and operands -> outputs unchanged, start_ready 0; release -> IDLE next cycle.
REQ-038 Drive rst_n = 0 at the 10th RUN cycle of a MUL -> next cycle all outputs at reset values, start_ready 1; a new ADD 2 + 3 then returns 5.
